arb2x1_stage: RTL and testbench

ARB2X1_STAGE -- requirements
Module: arb2x1_stage

---
 rtl/arb2x1_stage.sv | 125 ++++++++++++
 tb/tb_arb2x1_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb2x1_stage.sv
// -----------------------------------------------------------------------------
// arb2x1_stage
//
// Two-source round-robin arbitration stage with a one-entry holding slot per
// source and a registered output. Each source hands an operand into its own
// slot. The output register takes the next operand from a full slot whenever
// it is empty or being consumed. When both slots are full, the source that did
// not win last time is chosen, so two busy sources strictly alternate.
//
// Ports
//   Clk      : single clock, all state updates on the rising edge
//   Rst      : asynchronous reset, active-low
//   a_data   : source A operand            (DATAWIDTH)
//   a_valid  : source A offers a_data
//   a_ready  : slot A empty (registered, no input-to-ready path)
//   b_data   : source B operand            (DATAWIDTH)
//   b_valid  : source B offers b_data
//   b_ready  : slot B empty (registered, no input-to-ready path)
//   d        : registered selected operand (DATAWIDTH)
//   d_valid  : d holds an unconsumed result
//   d_ready  : consumer accepts d
//   sel      : registered source tag of d, 1 = A, 0 = B
// -----------------------------------------------------------------------------
module arb2x1_stage #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a_data,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [DATAWIDTH-1:0] b_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    output logic [DATAWIDTH-1:0] d,
    output logic                 d_valid,
    input  logic                 d_ready,
    output logic                 sel
);

    // Slot state (stage p0)
    logic                 full_a_p0;
    logic                 full_b_p0;
    logic [DATAWIDTH-1:0] slot_a_p0;
    logic [DATAWIDTH-1:0] slot_b_p0;
    // 1 when A won the most recent grant; reset to B so A wins the first tie
    logic                 last_grant_a;

    // Output register (stage p1)
    logic [DATAWIDTH-1:0] d_p1;
    logic                 vld_p1;
    logic                 sel_p1;

    logic                 acc_a;
    logic                 acc_b;
    logic                 load;
    logic                 grant_a;

    // Round-robin pick: a lone full slot wins outright; on a tie the source
    // that lost last time wins.
    function automatic logic pick_a(input logic fa, input logic fb, input logic last_a);
        return fa && (!fb || !last_a);
    endfunction

    assign a_ready = !full_a_p0;
    assign b_ready = !full_b_p0;

    assign acc_a   = a_valid && !full_a_p0;
    assign acc_b   = b_valid && !full_b_p0;
    assign load    = (!vld_p1 || d_ready) && (full_a_p0 || full_b_p0);
    assign grant_a = pick_a(full_a_p0, full_b_p0, last_grant_a);

    // ---- stage p0: slot capture ----
    // Slot payloads are meaningless while the full flag is clear, so they are
    // not reset.
    always_ff @(posedge Clk) begin
        if (acc_a) slot_a_p0 <= a_data;
        if (acc_b) slot_b_p0 <= b_data;
    end

    // A slot cannot be accepted into and granted on the same edge: accept
    // needs it empty, grant needs it full.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            full_a_p0    <= 1'b0;
            full_b_p0    <= 1'b0;
            last_grant_a <= 1'b0;
        end else begin
            if (acc_a)
                full_a_p0 <= 1'b1;
            else if (load && grant_a)
                full_a_p0 <= 1'b0;

            if (acc_b)
                full_b_p0 <= 1'b1;
            else if (load && !grant_a)
                full_b_p0 <= 1'b0;

            if (load)
                last_grant_a <= grant_a;
        end
    end

    // ---- stage p1: output register ----
    // d and sel are cleared on reset so a flushed stage presents a known value.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            d_p1   <= '0;
            sel_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (load) begin
            d_p1   <= grant_a ? slot_a_p0 : slot_b_p0;
            sel_p1 <= grant_a;
            vld_p1 <= 1'b1;
        end else if (d_ready) begin
            // Consumed with nothing to replace it; d and sel keep last values.
            vld_p1 <= 1'b0;
        end
    end

    assign d       = d_p1;
    assign d_valid = vld_p1;
    assign sel     = sel_p1;

endmodule

// File: tb/tb_arb2x1_stage.sv
module tb_arb2x1_stage;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic [W-1:0] a_data = '0;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [W-1:0] b_data = '0;
    logic         b_valid = 1'b0;
    logic         b_ready;
    logic [W-1:0] d;
    logic         d_valid;
    logic         d_ready = 1'b0;
    logic         sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per-source FIFOs of accepted items
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         hold_ok = 1'b0;

    arb2x1_stage #(.DATAWIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .d(d), .d_valid(d_valid), .d_ready(d_ready), .sel(sel)
    );

    always #5 Clk = ~Clk;

    task automatic chk8(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    // Called just after a rising edge; pulses reset between edges.
    task automatic do_reset;
        Rst = 1'b0;
        qa.delete();
        qb.delete();
        #2;
        Rst = 1'b1;
    endtask

    // Any reset invalidates the hold comparison
    initial forever begin
        @(negedge Rst);
        hold_ok = 1'b0;
    end

    // Monitor / scoreboard: observe transfers that will happen at the next
    // rising edge (inputs and registered outputs are stable at the falling edge).
    initial forever begin
        logic [W-1:0] pd;
        logic         ps;
        logic [W-1:0] e;
        @(negedge Clk);
        if (Rst) begin
            if (hold_ok) begin
                chk8("hold_d", d, pd);
                chk1("hold_sel", sel, ps);
                chk1("hold_vld", d_valid, 1'b1);
            end
            if (a_valid && a_ready) qa.push_back(a_data);
            if (b_valid && b_ready) qb.push_back(b_data);
            if (d_valid && d_ready) begin
                if (sel) begin
                    chk1("sb_a_expected_item", qa.size() != 0, 1'b1);
                    if (qa.size() != 0) begin
                        e = qa.pop_front();
                        chk8("sb_a_data", d, e);
                    end
                end else begin
                    chk1("sb_b_expected_item", qb.size() != 0, 1'b1);
                    if (qb.size() != 0) begin
                        e = qb.pop_front();
                        chk8("sb_b_data", d, e);
                    end
                end
            end
            hold_ok = d_valid && !d_ready;
            pd = d;
            ps = sel;
        end else begin
            hold_ok = 1'b0;
        end
    end

    initial begin
        logic         ra, rb;
        logic [W-1:0] e;
        bit           done;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk1("rst_dvalid", d_valid, 1'b0);
        chk8("rst_d", d, 8'h00);
        chk1("rst_sel", sel, 1'b0);
        chk1("rst_aready", a_ready, 1'b1);
        chk1("rst_bready", b_ready, 1'b1);
        Rst = 1'b1;

        // Single A item
        a_data = 8'h11; a_valid = 1'b1; d_ready = 1'b1;
        step;
        a_valid = 1'b0;
        chk1("single_no_bypass", d_valid, 1'b0);
        chk1("single_aready_full", a_ready, 1'b0);
        step;
        chk8("single_d", d, 8'h11);
        chk1("single_sel", sel, 1'b1);
        chk1("single_vld", d_valid, 1'b1);
        chk1("single_aready_free", a_ready, 1'b1);
        step;
        chk1("single_vld_drop", d_valid, 1'b0);
        chk8("single_d_kept", d, 8'h11);

        // Tie after reset: A first
        do_reset;
        a_data = 8'h0A; b_data = 8'h0B; a_valid = 1'b1; b_valid = 1'b1; d_ready = 1'b1;
        step;
        a_valid = 1'b0; b_valid = 1'b0;
        step;
        chk8("tie_d0", d, 8'h0A);
        chk1("tie_sel0", sel, 1'b1);
        step;
        chk8("tie_d1", d, 8'h0B);
        chk1("tie_sel1", sel, 1'b0);
        step;
        chk1("tie_vld_drop", d_valid, 1'b0);

        // Continuous streams: strict alternation, one per cycle
        do_reset;
        a_data = 8'h01; b_data = 8'h81; a_valid = 1'b1; b_valid = 1'b1; d_ready = 1'b1;
        for (int k = 0; k < 34; k++) begin
            ra = a_valid && a_ready;
            rb = b_valid && b_ready;
            step;
            if (ra) a_data = a_data + 8'd1;
            if (rb) b_data = b_data + 8'd1;
            if (k == 0) begin
                chk1("stream_first_empty", d_valid, 1'b0);
            end else begin
                int i;
                i = k - 1;
                e = (i % 2 == 0) ? 8'(1 + i / 2) : 8'(8'h81 + i / 2);
                chk1("stream_vld", d_valid, 1'b1);
                chk8("stream_d", d, e);
                chk1("stream_sel", sel, (i % 2 == 0) ? 1'b1 : 1'b0);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            step;
            done = !d_valid;
        end
        chk1("stream_drained", done, 1'b1);

        // Backpressure with both slots full
        do_reset;
        d_ready = 1'b0;
        a_data = 8'h21; b_data = 8'h31; a_valid = 1'b1; b_valid = 1'b1;
        step;
        a_data = 8'h22; b_valid = 1'b0;
        chk1("bp_first_empty", d_valid, 1'b0);
        step;
        chk8("bp_load_d", d, 8'h21);
        chk1("bp_load_sel", sel, 1'b1);
        chk1("bp_aready_free", a_ready, 1'b1);
        chk1("bp_bready_full", b_ready, 1'b0);
        step;
        a_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step;
            chk8("bp_frozen_d", d, 8'h21);
            chk1("bp_frozen_sel", sel, 1'b1);
            chk1("bp_frozen_vld", d_valid, 1'b1);
            chk1("bp_aready", a_ready, 1'b0);
            chk1("bp_bready", b_ready, 1'b0);
        end
        d_ready = 1'b1;
        step;
        chk8("bp_drain0_d", d, 8'h31);
        chk1("bp_drain0_sel", sel, 1'b0);
        step;
        chk8("bp_drain1_d", d, 8'h22);
        chk1("bp_drain1_sel", sel, 1'b1);
        step;
        chk1("bp_drain_done", d_valid, 1'b0);

        // Asynchronous reset mid-stream
        do_reset;
        d_ready = 1'b0;
        a_data = 8'h41; b_data = 8'h51; a_valid = 1'b1; b_valid = 1'b1;
        step;
        a_data = 8'h42; b_valid = 1'b0;
        step;
        step;
        a_valid = 1'b0;
        chk1("mid_pre_vld", d_valid, 1'b1);
        chk1("mid_pre_aready", a_ready, 1'b0);
        #2;
        Rst = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        chk1("mid_rst_vld", d_valid, 1'b0);
        chk8("mid_rst_d", d, 8'h00);
        chk1("mid_rst_sel", sel, 1'b0);
        chk1("mid_rst_aready", a_ready, 1'b1);
        chk1("mid_rst_bready", b_ready, 1'b1);
        a_data = 8'h5A; b_data = 8'h5B; a_valid = 1'b1; b_valid = 1'b1; d_ready = 1'b1;
        step;
        chk1("mid_no_xfer_a", a_ready, 1'b1);
        chk1("mid_no_xfer_b", b_ready, 1'b1);
        Rst = 1'b1;
        step;
        a_valid = 1'b0; b_valid = 1'b0;
        chk1("mid_accept_a", a_ready, 1'b0);
        step;
        chk8("mid_tie_d0", d, 8'h5A);
        chk1("mid_tie_sel0", sel, 1'b1);
        step;
        chk8("mid_tie_d1", d, 8'h5B);
        chk1("mid_tie_sel1", sel, 1'b0);
        step;

        // Random traffic against the scoreboard
        do_reset;
        for (int k = 0; k < 10000; k++) begin
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            a_data  = 8'($urandom);
            b_data  = 8'($urandom);
            d_ready = ($urandom_range(0, 3) != 0);
            step;
        end
        a_valid = 1'b0; b_valid = 1'b0; d_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step;
            done = !d_valid && a_ready && b_ready;
        end
        step;
        chk1("rand_drained", done, 1'b1);
        chk1("rand_qa_empty", qa.size() == 0, 1'b1);
        chk1("rand_qb_empty", qb.size() == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
